// File: rtl/if_id_skid_latch.sv
// if_id_skid_latch
//   Two-entry IF/ID pipeline latch. It has a main register that drives the
//   decode-side outputs and a skid register that catches one extra entry, so
//   in_ready can be a registered signal with no combinational path from
//   out_ready. It also counts the cycles in which decode applies back-pressure.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   fetch-side handshake (in_ready is registered)
//   npc, instr          fetch-side payload
//   flush               synchronous squash of all held entries
//   out_valid/out_ready decode-side handshake
//   npcout, instrout    decode-side payload (0 / NOP_INSTR when empty)
//   stall_cnt           saturating count of out_valid && !out_ready cycles
//
// state | meaning
// EMPTY | no entry held, outputs show 0 / NOP_INSTR
// FULL  | main holds the head entry, skid unused
// SKID  | main holds head, skid holds the next entry, input blocked

module if_id_skid_latch #(
  parameter int                   ADDR_W    = 32,
  parameter int                   INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000000,
  parameter int                   STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  npc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  npcout,
  output logic [INSTR_W-1:0] instrout,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  main_npc_q, main_npc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]  skid_npc_q, skid_npc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic pop;

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    main_npc_d   = main_npc_q;
    main_instr_d = main_instr_q;
    skid_npc_d   = skid_npc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      // Flush wins over any accept/pop in the same cycle.
      state_d      = EMPTY;
      main_npc_d   = '0;
      main_instr_d = NOP_INSTR;
      skid_npc_d   = '0;
      skid_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_npc_d   = npc;
            main_instr_d = instr;
            state_d      = FULL;
          end
        end
        FULL: begin
          if (accept && pop) begin
            main_npc_d   = npc;
            main_instr_d = instr;
          end else if (accept) begin
            skid_npc_d   = npc;
            skid_instr_d = instr;
            state_d      = SKID;
          end else if (pop) begin
            // Clear main so the empty outputs read 0 / NOP_INSTR.
            main_npc_d   = '0;
            main_instr_d = NOP_INSTR;
            state_d      = EMPTY;
          end
        end
        SKID: begin
          if (pop) begin
            main_npc_d   = skid_npc_q;
            main_instr_d = skid_instr_q;
            skid_npc_d   = '0;
            skid_instr_d = NOP_INSTR;
            state_d      = FULL;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_npc_d   = '0;
          main_instr_d = NOP_INSTR;
          skid_npc_d   = '0;
          skid_instr_d = NOP_INSTR;
        end
      endcase
    end

    // Ready and valid are registered from the next state, which keeps them
    // free of any combinational dependency on out_ready.
    in_ready_d  = (state_d != SKID);
    out_valid_d = (state_d != EMPTY);

    // The counter uses the current cycle's view and is not cleared by flush.
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_npc_q   <= '0;
      main_instr_q <= NOP_INSTR;
      skid_npc_q   <= '0;
      skid_instr_q <= NOP_INSTR;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_npc_q   <= main_npc_d;
      main_instr_q <= main_instr_d;
      skid_npc_q   <= skid_npc_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign npcout    = main_npc_q;
  assign instrout  = main_instr_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/if_id_skid_latch.md
IF_ID_SKID_LATCH -- requirements
Module: if_id_skid_latch

Interface
REQ-001 Parameter ADDR_W, default 32, width of the next-PC path.
REQ-002 Parameter INSTR_W, default 32, width of the instruction path.
REQ-003 Parameter NOP_INSTR, default 32'h00000000, instruction value presented when no valid entry is held.
REQ-004 Parameter STALL_W, default 16, width of the stall counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  fetch stage offers npc/instr this cycle.
REQ-008 in_ready  output  1  latch can accept an entry this cycle.
REQ-009 npc  input  ADDR_W  next PC from fetch.
REQ-010 instr  input  INSTR_W  fetched instruction.
REQ-011 flush  input  1  synchronous squash of all held entries (branch taken or exception).
REQ-012 out_valid  output  1  npcout/instrout hold a valid entry.
REQ-013 out_ready  input  1  decode stage consumes the entry this cycle.
REQ-014 npcout  output  ADDR_W  next PC to decode.
REQ-015 instrout  output  INSTR_W  instruction to decode.
REQ-016 stall_cnt  output  STALL_W  count of back-pressure cycles.

Function
REQ-017 Storage SHALL be a main register that drives the outputs plus one skid register; capacity is 2 entries.
REQ-018 Accept SHALL mean in_valid && in_ready; pop SHALL mean out_valid && out_ready.
REQ-019 States SHALL be EMPTY (0 entries), FULL (main only) and SKID (main + skid); out_valid = (state != EMPTY).
REQ-020 in_ready SHALL be a registered value equal to (state != SKID), with no combinational path from out_ready.
REQ-021 In EMPTY, accept SHALL load main and move to FULL one cycle later (latency 1 clock from input to output).
REQ-022 In FULL: accept && pop SHALL load main with the input and stay in FULL; accept && !pop SHALL load skid and go to SKID; pop && !accept SHALL go to EMPTY; otherwise hold.
REQ-023 In SKID: pop SHALL move skid to main and go to FULL; otherwise hold; no input is accepted.
REQ-024 Entries SHALL be delivered in strict acceptance order; none is dropped or duplicated.
REQ-025 When state is EMPTY, npcout SHALL be 0 and instrout SHALL be NOP_INSTR.
REQ-026 Flush SHALL take priority over accept and pop in the same cycle: next state EMPTY, both registers cleared to npc 0 / NOP_INSTR, and in_valid ignored that cycle.
REQ-027 stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready, saturate at all-ones, and not be cleared by flush.
REQ-028 Outputs SHALL change only on clk edges or on rst assertion.

Reset
REQ-029 While rst = 1: state EMPTY, out_valid 0, in_ready 1, npcout 0, instrout NOP_INSTR, skid cleared, stall_cnt 0.
REQ-030 Assertion of rst in any state, including SKID mid-transfer, SHALL discard all entries immediately, without waiting for a clock edge.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Streaming: out_ready 1, offer 12345678/87654321 then DEADBEEF/CAFEBABE on consecutive edges -> each appears one cycle later, out_valid 1 for 2 cycles, in_ready stays 1, stall_cnt 0.
REQ-033 Back-pressure: out_ready 0, offer three entries A, B, C -> A held at output, B goes to skid, in_ready falls after B, C is not accepted until released, stall_cnt increments every cycle; raise out_ready -> A, B, C delivered in order.
REQ-034 Flush in SKID, with in_valid 1 in the same cycle -> next cycle out_valid 0, instrout 00000000, npcout 0, in_ready 1, offered entry lost, stall_cnt retained.
REQ-035 Async reset mid-cycle while in SKID -> outputs reach reset values before the next edge; stall_cnt 0.
REQ-036 Saturation: STALL_W = 4, hold back-pressure for 20 cycles -> stall_cnt stops at 4'hF.
